// File: rtl/alsu_param.sv
// alsu_param: parametrised arithmetic-logic-shift unit with a two-stage pipeline.
// Stage 1 registers every input each cycle. Stage 2 evaluates the registered
// request into out/leds/err when the request was valid.
// Build option: ALSU_LED_BLINK_EN. When defined, each invalid result toggles leds.
// When undefined, an invalid result sets leds to all-ones.
module alsu_param #(
  parameter int WIDTH = 3,
  parameter int LED_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 cin,
  input  logic                 serial_in,
  input  logic [2:0]           opcode,
  input  logic                 red_op_A,
  input  logic                 red_op_B,
  input  logic                 bypass_A,
  input  logic                 bypass_B,
  input  logic                 direction,
  output logic [2*WIDTH-1:0]   out,
  output logic [LED_W-1:0]     leds,
  output logic                 valid_out,
  output logic                 err
);

  localparam int OUT_W = 2*WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ser;
    logic [2:0]       op;
    logic             ra;
    logic             rb;
    logic             ba;
    logic             bb;
    logic             dir;
  } req_t;

  req_t             req, s1;
  logic             v1;
  logic [OUT_W-1:0] sa, sb, nxt_out;
  logic [LED_W-1:0] nxt_leds;
  logic             invalid, nxt_err;

  assign req = '{a: A, b: B, cin: cin, ser: serial_in, op: opcode,
                 ra: red_op_A, rb: red_op_B, ba: bypass_A, bb: bypass_B,
                 dir: direction};

  // Stage 1: capture the whole request every cycle, qualified by v1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      v1 <= 1'b0;
    end else begin
      s1 <= req;
      v1 <= valid_in;
    end
  end

  assign sa = {{WIDTH{s1.a[WIDTH-1]}}, s1.a};
  assign sb = {{WIDTH{s1.b[WIDTH-1]}}, s1.b};

  // Opcodes 6/7 are invalid. A reduction is invalid with anything but OR/XOR.
  assign invalid = (s1.op[2] & s1.op[1]) |
                   ((s1.ra | s1.rb) & (s1.op[2:1] != 2'b00));

  // Stage 2 result selection. Bypass outranks the invalid check.
  always_comb begin
    nxt_out = out;
    nxt_err = 1'b0;
    if (s1.ba)
      nxt_out = sa;
    else if (s1.bb)
      nxt_out = sb;
    else if (invalid) begin
      nxt_out = '0;
      nxt_err = 1'b1;
    end else if (s1.ra)
      nxt_out = {{(OUT_W-1){1'b0}}, (s1.op[0] ? ^s1.a : |s1.a)};
    else if (s1.rb)
      nxt_out = {{(OUT_W-1){1'b0}}, (s1.op[0] ? ^s1.b : |s1.b)};
    else begin
      case (s1.op)
        3'd0: nxt_out = sa | sb;
        3'd1: nxt_out = sa ^ sb;
        3'd2: nxt_out = sa + sb + {{(OUT_W-1){1'b0}}, s1.cin};
        // Low OUT_W bits of the product of sign-extended operands equal the signed product.
        3'd3: nxt_out = sa * sb;
        3'd4: nxt_out = s1.dir ? {out[OUT_W-2:0], s1.ser} : {s1.ser, out[OUT_W-1:1]};
        3'd5: nxt_out = s1.dir ? {out[OUT_W-2:0], out[OUT_W-1]} : {out[0], out[OUT_W-1:1]};
        default: nxt_out = out;
      endcase
    end
  end

  // LED pattern for the next result: cleared on good results, flagged on invalid ones.
  always_comb begin
    nxt_leds = '0;
    if (nxt_err) begin
`ifdef ALSU_LED_BLINK_EN
      nxt_leds = ~leds;
`else
      nxt_leds = '1;
`endif
    end
  end

  // Stage 2 register. out and leds hold across bubbles, and err is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      leds      <= '0;
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid_out <= v1;
      if (v1) begin
        out  <= nxt_out;
        leds <= nxt_leds;
        err  <= nxt_err;
      end else begin
        err  <= 1'b0;
      end
    end
  end

endmodule
